// File: rtl/coreapb3_pkg.sv
// Shared definitions for the CoreAPB3 initiator: FSM state encoding, beat
// address stride and data-width helpers.
package coreapb3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Narrow-bus beats land on consecutive word addresses.
  localparam logic [31:0] BEAT_OFFSET = 32'd4;

  function automatic bit dwidth_is_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  function automatic int beats_per_word(input int w);
    return 32 / w;
  endfunction

endpackage

// File: rtl/coreapb3_initiator_tmo.sv
// Saturating PREADY wait counter; flags expiry on the ACCESS cycle whose
// increment reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 never expires.
module coreapb3_initiator_tmo #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : '1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != TERM)) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign expired = TMO_EN && enable && (w_cnt_inc == TERM);

endmodule

// File: rtl/coreapb3_initiator.sv
// APB3 initiator: converts a 32-bit request/response handshake into one or
// more APB SETUP/ACCESS beats, packing narrow read data least-significant first.
module coreapb3_initiator
  import coreapb3_pkg::*;
#(
  parameter int APB_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        RSP_TIMEOUT,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int NBEATS = beats_per_word(APB_DWIDTH);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  if (!dwidth_is_legal(APB_DWIDTH)) begin : g_bad_width
    $error("coreapb3_initiator: APB_DWIDTH must be 8, 16 or 32");
  end

  apb_state_e r_state;
  apb_state_e w_state_next;

  logic                  r_write;
  logic [29:0]           r_addr_word;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_timeout;
  logic [BW-1:0]         r_beat;

  logic                  w_last_beat;
  logic [31:0]           w_lane_base;
  logic [31:0]           w_paddr;
  logic [APB_DWIDTH-1:0] w_wslice;
  logic                  w_tmo_clear;
  logic                  w_tmo_enable;
  logic                  w_tmo_expired;
  logic                  w_unused_addr_lsb;

  // Low address bits are forced to a word boundary, so they are never stored.
  assign w_unused_addr_lsb = ^REQ_ADDR[1:0];

  if (APB_DWIDTH < 32) begin : g_prdata_hi
    logic w_unused_prdata_hi;
    assign w_unused_prdata_hi = ^PRDATA[31:APB_DWIDTH];
  end

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_lane_base = 32'(r_beat) * APB_DWIDTH;
  assign w_paddr     = {r_addr_word, 2'b00} + (BEAT_OFFSET * 32'(r_beat));
  assign w_wslice    = r_wdata[w_lane_base +: APB_DWIDTH];

  assign w_tmo_clear  = (r_state != ST_ACCESS);
  assign w_tmo_enable = (r_state == ST_ACCESS) && !PREADY;

  coreapb3_initiator_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .clear  (w_tmo_clear),
    .enable (w_tmo_enable),
    .expired(w_tmo_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (REQ_VALID) w_state_next = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR || w_last_beat) w_state_next = ST_RESP;
          else                        w_state_next = ST_SETUP;
        end else if (w_tmo_expired) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RSP_READY) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY   = 1'b0;
    RSP_VALID   = 1'b0;
    RSP_RDATA   = '0;
    RSP_ERR     = 1'b0;
    RSP_TIMEOUT = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    PADDR       = '0;
    PWRITE      = 1'b0;
    PWDATA      = '0;
    case (r_state)
      ST_IDLE: begin
        REQ_READY = 1'b1;
      end
      ST_SETUP, ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == ST_ACCESS);
        PADDR   = w_paddr;
        PWRITE  = r_write;
        PWDATA  = 32'(w_wslice);
      end
      ST_RESP: begin
        RSP_VALID   = 1'b1;
        RSP_ERR     = r_err;
        RSP_TIMEOUT = r_timeout;
        // Partial read data is dropped once any beat fails.
        RSP_RDATA   = (r_write || r_err || r_timeout) ? '0 : r_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_write     <= 1'b0;
      r_addr_word <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            r_write     <= REQ_WRITE;
            r_addr_word <= REQ_ADDR[31:2];
            r_wdata     <= REQ_WDATA;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_beat      <= '0;
          end
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (!r_write) r_rdata[w_lane_base +: APB_DWIDTH] <= PRDATA[APB_DWIDTH-1:0];
            if (PSLVERR)          r_err  <= 1'b1;
            else if (!w_last_beat) r_beat <= r_beat + 1'b1;
          end else if (w_tmo_expired) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coreapb3_initiator.sv
// Randomized scoreboard bench for coreapb3_initiator across 8/16/32-bit APB
// widths with a per-beat slave plan and a transaction-level response model.
module tb_coreapb3_initiator;

  localparam int NTX = 40;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
    int          lat;
    int          nbeats;
    int          t_acc;
  } rsp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   done [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s: got 0x%08h required 0x%08h", cfg, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W   = (gi == 0) ? 8 : ((gi == 1) ? 16 : 32);
    localparam int TMO = (gi == 0) ? 4 : ((gi == 1) ? 0 : 256);
    localparam int NB  = 32 / W;
    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - W);

    logic        rst_n, req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;

    coreapb3_initiator #(
      .APB_DWIDTH    (W),
      .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .PCLK       (clk),
      .PRESETN    (rst_n),
      .REQ_VALID  (req_valid),
      .REQ_READY  (req_ready),
      .REQ_WRITE  (req_write),
      .REQ_ADDR   (req_addr),
      .REQ_WDATA  (req_wdata),
      .RSP_VALID  (rsp_valid),
      .RSP_READY  (rsp_ready),
      .RSP_RDATA  (rsp_rdata),
      .RSP_ERR    (rsp_err),
      .RSP_TIMEOUT(rsp_tmo),
      .PSEL       (psel),
      .PENABLE    (penable),
      .PADDR      (paddr),
      .PWRITE     (pwrite),
      .PWDATA     (pwdata),
      .PRDATA     (prdata),
      .PREADY     (pready),
      .PSLVERR    (pslverr)
    );

    rsp_t        sb[$];
    rsp_t        cur_e;
    int          plan_w [4];
    bit          plan_e [4];
    logic [31:0] plan_d [4];
    logic [31:0] exp_addr [4];
    logic [31:0] exp_wd [4];
    bit          exp_wr;
    int          setup_seen = 0;
    int          rsp_done = 0;
    int          cur = 0, acc = 0;
    bit          seen = 0, hs_pend = 0;
    int          hold = 0, hold_req = 0;

    task automatic run_txn(input int t, input bit abort);
      logic [31:0] a, wd;
      bit          wr, quiet, hit;
      rsp_t        e;
      int          k, start, tgt, lat;
      @(negedge clk);
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      wd = $urandom;
      for (int b = 0; b < NB; b++) begin
        plan_w[b] = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
        plan_e[b] = ($urandom_range(0, 9) == 0);
        plan_d[b] = $urandom & MASK;
        if (t == 0) begin
          plan_w[b] = (gi == 1) ? 3 : 0;
          plan_e[b] = 1'b0;
          plan_d[b] = (32'h11 * (b + 1)) & MASK;
        end else if (t == 1 && gi == 0) begin
          plan_w[b] = 0;
          plan_e[b] = (b == 1);
        end else if (abort) begin
          plan_w[b] = (TMO != 0 && TMO <= 40) ? TMO - 1 : 40;
          plan_e[b] = 1'b0;
        end
      end
      if (t == 0) begin
        wr = (gi != 0);
        a  = (gi == 0) ? 32'h100 : 32'h10;
        wd = (gi == 1) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      end else if (t == 1 && gi == 0) begin
        wr = 1'b0;
        a  = 32'h200;
      end else if (t == 5) begin
        plan_w[0] = (TMO == 0) ? 1000 : 300;
      end
      for (int b = 0; b < NB; b++) begin
        exp_addr[b] = {a[31:2], 2'b00} + 32'(4 * b);
        exp_wd[b]   = (wd >> (b * W)) & MASK;
      end
      // Reference: walk the beats, stop at first timeout or slave error.
      e.rdata = '0; e.err = 1'b0; e.tmo = 1'b0; e.nbeats = 0; lat = 0;
      for (int b = 0; b < NB; b++) begin
        e.nbeats++;
        if (TMO != 0 && plan_w[b] >= TMO) begin
          e.tmo = 1'b1;
          lat += 1 + TMO;
          break;
        end
        lat += 2 + plan_w[b];
        if (plan_e[b]) begin
          e.err = 1'b1;
          break;
        end
        e.rdata |= plan_d[b] << (b * W);
      end
      if (wr || e.err || e.tmo) e.rdata = '0;
      e.lat = lat + 1;
      exp_wr = wr;

      k = 0;
      while (!req_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk(gi, "req_ready_idle", {31'd0, req_ready}, 32'd1);
      setup_seen = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      e.t_acc = cyc;
      sb.push_back(e);
      start = rsp_done;
      quiet = 1'b0; hit = 1'b0; k = 0;
      tgt = (NB > 2) ? 2 : NB - 1;
      @(negedge clk);
      while (rsp_done == start && k < e.lat + 50) begin
        if (abort && psel && penable && setup_seen == tgt + 1) begin
          #2;
          rst_n = 1'b0;
          req_valid = 1'b0;
          #1;
          chk(gi, "abort_psel", {31'd0, psel}, 32'd0);
          chk(gi, "abort_penable", {31'd0, penable}, 32'd0);
          chk(gi, "abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          chk(gi, "abort_req_ready", {31'd0, req_ready}, 32'd1);
          chk(gi, "abort_paddr", paddr, 32'd0);
          sb.delete();
          @(negedge clk);
          #2 rst_n = 1'b1;
          hit = 1'b1;
          break;
        end
        if (rsp_valid) quiet = 1'b1;
        if (quiet) begin
          req_valid = 1'b0;
        end else begin
          // Busy-time request noise must not disturb the captured request.
          req_valid = 1'($urandom_range(0, 1));
          req_write = 1'($urandom_range(0, 1));
          req_addr  = $urandom;
          req_wdata = $urandom;
        end
        @(negedge clk);
        k++;
      end
      req_valid = 1'b0;
      if (abort && !hit) begin
        checks++; failures++;
        $display("FAIL cfg%0d abort_point: got no ACCESS of beat %0d required one", gi, tgt);
      end else if (!abort && rsp_done == start) begin
        checks++; failures++;
        $display("FAIL cfg%0d rsp_wait: got no response after %0d cycles required one", gi, k);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
    endtask

    initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk(gi, "rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk(gi, "rst_psel", {31'd0, psel}, 32'd0);
      chk(gi, "rst_penable", {31'd0, penable}, 32'd0);
      chk(gi, "rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk(gi, "rst_paddr", paddr, 32'd0);
      chk(gi, "rst_pwdata", pwdata, 32'd0);
      rst_n = 1'b1;
      for (int t = 0; t < NTX; t++) run_txn(t, t == NTX / 2);
      done[gi] = 1'b1;
    end

    // APB slave: follows the per-beat plan and checks the bus against it.
    initial begin
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      forever begin
        @(negedge clk);
        if (psel && !penable) begin
          cur = setup_seen;
          if (cur >= NB) begin
            checks++; failures++;
            $display("FAIL cfg%0d beat_count: got beat %0d required at most %0d", gi, cur, NB - 1);
            cur = NB - 1;
          end
          setup_seen++;
          acc = 0;
          chk(gi, "setup_paddr", paddr, exp_addr[cur]);
          chk(gi, "setup_pwrite", {31'd0, pwrite}, {31'd0, exp_wr});
          chk(gi, "setup_pwdata", pwdata, exp_wd[cur]);
          pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
        end else if (psel && penable) begin
          chk(gi, "access_paddr", paddr, exp_addr[cur]);
          chk(gi, "access_pwrite", {31'd0, pwrite}, {31'd0, exp_wr});
          chk(gi, "access_pwdata", pwdata, exp_wd[cur]);
          if (acc == plan_w[cur]) begin
            pready = 1'b1; pslverr = plan_e[cur]; prdata = ($urandom & ~MASK) | plan_d[cur];
          end else begin
            pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
          end
          acc++;
        end else begin
          pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
        end
      end
    end

    // Response monitor: pops the scoreboard on each new RSP_VALID.
    initial begin
      rsp_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (hs_pend) begin
          hs_pend = 1'b0;
          chk(gi, "rsp_drop", {31'd0, rsp_valid}, 32'd0);
          chk(gi, "req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
          rsp_done++;
        end
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1'b1; hold = 0; hold_req = $urandom_range(0, 6);
            if (sb.size() == 0) begin
              checks++; failures++;
              $display("FAIL cfg%0d unexpected_rsp: got RSP_VALID required none", gi);
            end else begin
              cur_e = sb.pop_front();
              chk(gi, "latency", 32'(cyc - cur_e.t_acc), 32'(cur_e.lat));
              chk(gi, "beats_issued", 32'(setup_seen), 32'(cur_e.nbeats));
            end
          end
          chk(gi, "rsp_rdata", rsp_rdata, cur_e.rdata);
          chk(gi, "rsp_err", {31'd0, rsp_err}, {31'd0, cur_e.err});
          chk(gi, "rsp_timeout", {31'd0, rsp_tmo}, {31'd0, cur_e.tmo});
          chk(gi, "resp_req_ready", {31'd0, req_ready}, 32'd0);
          chk(gi, "resp_psel", {31'd0, psel}, 32'd0);
          rsp_ready = (hold >= hold_req);
          hold++;
          if (rsp_ready) begin
            hs_pend = 1'b1;
            seen = 1'b0;
          end
        end else begin
          seen = 1'b0;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 80000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 80000) begin
      failures++;
      $display("FAIL watchdog: got %0d cycles without completion required under 80000", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
